// File: rtl/dvbs2_fir_engine_if.sv
// Bus bundle for the DVB-S2 FIR engine: run control, coefficient port,
// sample handshake and result outputs.
interface dvbs2_fir_engine_if #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned NTAPS    = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUT_W    = 32
);
  localparam int unsigned AW = $clog2(NTAPS);

  logic                      enable;
  logic                      start;
  logic                      coef_we;
  logic [AW-1:0]             coef_addr;
  logic [COEF_W-1:0]         coef_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*IN_W-1:0]  in_data;
  logic                      out_valid;
  logic [CHANNELS*OUT_W-1:0] out_data;
  logic                      sat;
  logic                      busy;

  modport master (
    output enable, start, coef_we, coef_addr, coef_data, in_valid, in_data,
    input  in_ready, out_valid, out_data, sat, busy
  );

  modport slave (
    input  enable, start, coef_we, coef_addr, coef_data, in_valid, in_data,
    output in_ready, out_valid, out_data, sat, busy
  );
endinterface

// File: rtl/dvbs2_fir_engine.sv
// Multi-channel tap-serial FIR output stage: one MAC per channel per cycle,
// shared runtime-loadable coefficients, shift + saturate to signed OUT_W.
module dvbs2_fir_engine #(
  parameter int unsigned IN_W     = 12,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned NTAPS    = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned SHIFT    = 0
) (
  input  logic               clk_600MHz,
  input  logic               reset,
  dvbs2_fir_engine_if.slave  bus
);

  localparam int unsigned AW = $clog2(NTAPS);
  localparam int unsigned PW = IN_W + COEF_W;
  localparam int unsigned WW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [WW-1:0] OUT_MAX =
    signed'({{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [WW-1:0] OUT_MIN = ~OUT_MAX;

  if (NTAPS < 2) begin : g_bad_ntaps
    $error("dvbs2_fir_engine: NTAPS must be at least 2");
  end
  if (ACC_W < IN_W + COEF_W + $clog2(NTAPS)) begin : g_bad_acc_w
    $error("dvbs2_fir_engine: ACC_W too narrow for IN_W+COEF_W+clog2(NTAPS)");
  end

  typedef enum logic [1:0] {IDLE, READY, MAC, DONE} state_e;

  state_e                    state_q;
  logic                      armed_q;
  logic                      busy_q;
  logic                      sat_q;
  logic [AW-1:0]             tap_q;
  logic signed [IN_W-1:0]    x_q   [CHANNELS][NTAPS];
  logic signed [COEF_W-1:0]  h_q   [NTAPS];
  logic signed [ACC_W-1:0]   acc_q [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] out_data_q;

  logic signed [PW-1:0]      prod_c [CHANNELS];
  logic signed [ACC_W-1:0]   acc_d  [CHANNELS];
  logic signed [WW-1:0]      wide_c [CHANNELS];
  logic [CHANNELS*OUT_W-1:0] res_d;
  logic                      clip_d;
  logic                      coef_wr_ok;
  logic                      last_tap;

  // Coefficients may only change while no sample is being filtered.
  assign coef_wr_ok = bus.coef_we && ((state_q == IDLE) || (state_q == READY))
                      && (32'(bus.coef_addr) < NTAPS);
  assign last_tap   = (tap_q == AW'(NTAPS - 1));

  // Current-tap MAC and the shifted, clamped view of the updated sum.
  always_comb begin
    clip_d = 1'b0;
    res_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod_c[c] = PW'(x_q[c][tap_q]) * PW'(h_q[tap_q]);
      acc_d[c]  = acc_q[c] + ACC_W'(prod_c[c]);
      wide_c[c] = WW'(acc_d[c] >>> SHIFT);
      if (wide_c[c] > OUT_MAX) begin
        wide_c[c] = OUT_MAX;
        clip_d    = 1'b1;
      end else if (wide_c[c] < OUT_MIN) begin
        wide_c[c] = OUT_MIN;
        clip_d    = 1'b1;
      end
      res_d[c*OUT_W +: OUT_W] = OUT_W'(wide_c[c]);
    end
  end

  always_ff @(posedge clk_600MHz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      sat_q      <= 1'b0;
      tap_q      <= '0;
      out_data_q <= '0;
      for (int k = 0; k < NTAPS; k++) h_q[k] <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
        for (int k = 0; k < NTAPS; k++) x_q[c][k] <= '0;
      end
    end else begin
      if (coef_wr_ok) h_q[bus.coef_addr] <= signed'(bus.coef_data);
      // enable low freezes every datapath and state register.
      if (bus.enable) begin
        unique case (state_q)
          IDLE: begin
            if (bus.start || armed_q) begin
              armed_q <= 1'b1;
              state_q <= READY;
            end
          end
          READY: begin
            if (bus.in_valid) begin
              for (int c = 0; c < CHANNELS; c++) begin
                x_q[c][0] <= signed'(bus.in_data[c*IN_W +: IN_W]);
                for (int k = 1; k < NTAPS; k++) x_q[c][k] <= x_q[c][k-1];
                acc_q[c] <= '0;
              end
              tap_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= MAC;
            end
          end
          MAC: begin
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
            tap_q <= tap_q + AW'(1);
            // Result is captured on the final tap so it is valid throughout DONE.
            if (last_tap) begin
              tap_q      <= '0;
              out_data_q <= res_d;
              sat_q      <= sat_q | clip_d;
              state_q    <= DONE;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= READY;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Handshake and strobe track enable directly so a frozen engine never signals.
  assign bus.in_ready  = (state_q == READY) && bus.enable;
  assign bus.out_valid = (state_q == DONE) && bus.enable;
  assign bus.out_data  = out_data_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dvbs2_fir_engine.sv
// Bench for dvbs2_fir_engine: a 32-bit-output and a 16-bit-output engine run
// in lockstep on identical stimulus, results checked against a reference model.
module tb_dvbs2_fir_engine;

  localparam int NT = 16;

  typedef struct packed {
    logic [63:0] d32;
    logic [31:0] d16;
  } exp_t;

  logic clk_600MHz = 1'b0;
  logic reset;
  always #5 clk_600MHz = ~clk_600MHz;

  dvbs2_fir_engine_if #(.IN_W(12), .COEF_W(16), .NTAPS(NT), .CHANNELS(2), .OUT_W(32)) ba ();
  dvbs2_fir_engine_if #(.IN_W(12), .COEF_W(16), .NTAPS(NT), .CHANNELS(2), .OUT_W(16)) bs ();

  assign bs.enable    = ba.enable;
  assign bs.start     = ba.start;
  assign bs.coef_we   = ba.coef_we;
  assign bs.coef_addr = ba.coef_addr;
  assign bs.coef_data = ba.coef_data;
  assign bs.in_valid  = ba.in_valid;
  assign bs.in_data   = ba.in_data;

  dvbs2_fir_engine #(.IN_W(12), .COEF_W(16), .NTAPS(NT), .CHANNELS(2),
                     .ACC_W(32), .OUT_W(32), .SHIFT(0)) u_dut32 (
    .clk_600MHz (clk_600MHz),
    .reset      (reset),
    .bus        (ba)
  );

  dvbs2_fir_engine #(.IN_W(12), .COEF_W(16), .NTAPS(NT), .CHANNELS(2),
                     .ACC_W(32), .OUT_W(16), .SHIFT(0)) u_dut16 (
    .clk_600MHz (clk_600MHz),
    .reset      (reset),
    .bus        (bs)
  );

  int   checks = 0;
  int   errors = 0;
  int   nvalid = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mh [NT];
  int   mx [2][NT];

  function automatic longint sat_to(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: shift the model delay lines and predict both engines' results.
  function automatic void model_push(input int s0, input int s1);
    longint acc [2];
    exp_t   e;
    for (int k = NT - 1; k > 0; k--) begin
      mx[0][k] = mx[0][k-1];
      mx[1][k] = mx[1][k-1];
    end
    mx[0][0] = s0;
    mx[1][0] = s1;
    for (int c = 0; c < 2; c++) begin
      acc[c] = 0;
      for (int k = 0; k < NT; k++) acc[c] += longint'(mx[c][k]) * longint'(mh[k]);
    end
    e.d32 = {32'(sat_to(acc[1], 32)), 32'(sat_to(acc[0], 32))};
    e.d16 = {16'(sat_to(acc[1], 16)), 16'(sat_to(acc[0], 16))};
    exp_q.push_back(e);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    for (int k = 0; k < NT; k++) begin
      mh[k] = 0; mx[0][k] = 0; mx[1][k] = 0;
    end
  endfunction

  always @(negedge clk_600MHz) begin
    if (ba.out_valid === 1'b1 || bs.out_valid === 1'b1) begin
      nvalid++;
      checks++;
      if (ba.out_valid !== bs.out_valid || exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_strobe: valid32=%b valid16=%b pending=%0d (required lockstep, pending>0)",
                 ba.out_valid, bs.out_valid, exp_q.size());
      end else begin
        mon_e = exp_q.pop_front();
        if (ba.out_data !== mon_e.d32 || bs.out_data !== mon_e.d16) begin
          errors++;
          $display("FAIL result_data: got32=%h got16=%h required32=%h required16=%h",
                   ba.out_data, bs.out_data, mon_e.d32, mon_e.d16);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_600MHz);
    #1;
  endtask

  task automatic write_coef(input int a, input int v, input bit applied);
    ba.coef_we   = 1'b1;
    ba.coef_addr = 4'(a);
    ba.coef_data = 16'(v);
    tick();
    ba.coef_we = 1'b0;
    if (applied) mh[a] = v;
  endtask

  task automatic send(input int s0, input int s1);
    bit ok = 1'b0;
    ba.in_valid = 1'b1;
    ba.in_data  = {12'(s1), 12'(s0)};
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_600MHz);
      if (ba.in_ready === 1'b1) begin
        ok = 1'b1;
        model_push(s0, s1);
      end
      tick();
    end
    ba.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: in_ready=0 for 100 cycles, required 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk_600MHz);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic start_pulse();
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
  endtask

  task automatic test_reset();
    ba.enable = 1'b0; ba.start = 1'b0; ba.coef_we = 1'b0; ba.coef_addr = '0;
    ba.coef_data = '0; ba.in_valid = 1'b0; ba.in_data = '0;
    reset = 1'b1;
    model_clear();
    repeat (3) tick();
    @(negedge clk_600MHz);
    checks++;
    if ({ba.in_ready, ba.out_valid, ba.sat, ba.busy, bs.in_ready, bs.out_valid, bs.sat, bs.busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: rdy/val/sat/busy 32=%b%b%b%b 16=%b%b%b%b, required all 0",
               ba.in_ready, ba.out_valid, ba.sat, ba.busy, bs.in_ready, bs.out_valid, bs.sat, bs.busy);
    end
    checks++;
    if (ba.out_data !== 64'h0 || bs.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got32=%h got16=%h, required 0", ba.out_data, bs.out_data);
    end
    tick();
    reset = 1'b0;
    ba.enable = 1'b1;
    repeat (3) tick();
    @(negedge clk_600MHz);
    checks++;
    if (ba.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_unarmed: in_ready=%b, required 0", ba.in_ready);
    end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
    start_pulse();
    send(1, 0);
    for (int i = 1; i < NT; i++) send(0, 0);
    wait_drain();
    checks++;
    if (ba.out_data !== {32'd0, 32'd16} || ba.sat !== 1'b0 || bs.sat !== 1'b0) begin
      errors++;
      $display("FAIL impulse_last: out=%h sat32=%b sat16=%b, required 00000000_00000010 and sat 0",
               ba.out_data, ba.sat, bs.sat);
    end
  endtask

  task automatic test_latency();
    bit found = 1'b0;
    int v0;
    ba.in_valid = 1'b1;
    ba.in_data  = {12'(77), 12'(-300)};
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_600MHz);
      if (ba.in_ready === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL latency_accept: in_ready never high, required 1");
    end else begin
      model_push(-300, 77);
      for (int rel = 1; rel <= NT + 2; rel++) begin
        @(negedge clk_600MHz);
        checks++;
        if (ba.in_ready !== 1'(rel == NT + 2) || ba.out_valid !== 1'(rel == NT + 1)) begin
          errors++;
          $display("FAIL latency_cycle t+%0d: in_ready=%b out_valid=%b, required %b %b",
                   rel, ba.in_ready, ba.out_valid, rel == NT + 2, rel == NT + 1);
        end
      end
    end
    ba.in_valid = 1'b0;
    v0 = nvalid;
    repeat (30) tick();
    checks++;
    if (nvalid != v0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL latency_no_extra: strobes=%0d pending=%0d, required 0 0", nvalid - v0, exp_q.size());
    end
  endtask

  task automatic test_sign_ext();
    write_coef(0, 1, 1'b1);
    for (int k = 1; k < NT; k++) write_coef(k, 0, 1'b1);
    send(2047, -5);
    wait_drain();
    checks++;
    if (ba.out_data !== {32'hFFFF_FFFB, 32'd2047} || bs.out_data !== {16'hFFFB, 16'h07FF}) begin
      errors++;
      $display("FAIL sign_ext: got32=%h got16=%h, required fffffffb000007ff fffb07ff",
               ba.out_data, bs.out_data);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < NT; k++) write_coef(k, 32767, 1'b1);
    for (int i = 0; i < NT; i++) send(2047, -2048);
    wait_drain();
    checks++;
    if (bs.out_data !== 32'h8000_7FFF || bs.sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_clip16: out=%h sat=%b, required 80007fff 1", bs.out_data, bs.sat);
    end
    checks++;
    if (ba.out_data[31:0] !== 32'(16 * 2047 * 32767) || ba.sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide32: ch0=%h sat=%b, required %h 0", ba.out_data[31:0], ba.sat,
               32'(16 * 2047 * 32767));
    end
    for (int i = 0; i < NT; i++) send(0, 0);
    wait_drain();
    checks++;
    if (bs.out_data !== 32'h0 || bs.sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: out=%h sat=%b, required 00000000 1", bs.out_data, bs.sat);
    end
  endtask

  task automatic test_coef_protect();
    for (int k = 0; k < NT; k++) write_coef(k, k - 8, 1'b1);
    for (int i = 0; i < 3; i++)
      send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
    send(1500, -1700);
    write_coef(2, 999, 1'b0);
    wait_drain();
    send(-33, 44);
    wait_drain();
    ba.coef_we = 1'b1; ba.coef_addr = 4'd0; ba.coef_data = 16'(-7);
    mh[0] = -7;
    ba.in_valid = 1'b1; ba.in_data = {12'(300), 12'(-400)};
    @(negedge clk_600MHz);
    checks++;
    if (ba.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL coef_coincident_ready: in_ready=%b, required 1", ba.in_ready);
    end else begin
      model_push(-400, 300);
    end
    tick();
    ba.coef_we = 1'b0; ba.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_mac();
    int v0;
    send(100, -100);
    repeat (7) tick();
    reset = 1'b1;
    model_clear();
    @(negedge clk_600MHz);
    checks++;
    if ({ba.in_ready, ba.out_valid, ba.busy, bs.sat, bs.busy} !== 5'b0 ||
        ba.out_data !== 64'h0 || bs.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_mac: rdy=%b val=%b busy=%b sat16=%b out32=%h out16=%h, required all 0",
               ba.in_ready, ba.out_valid, ba.busy, bs.sat, ba.out_data, bs.out_data);
    end
    v0 = nvalid;
    tick();
    reset = 1'b0;
    repeat (25) tick();
    @(negedge clk_600MHz);
    checks++;
    if (nvalid != v0 || ba.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: strobes=%0d in_ready=%b, required 0 0", nvalid - v0, ba.in_ready);
    end
    tick();
    for (int k = 0; k < NT; k++) write_coef(k, 2 * k + 3, 1'b1);
    start_pulse();
    send(1, 0);
    for (int i = 1; i < NT; i++) send(0, 0);
    wait_drain();
    checks++;
    if (ba.out_data !== {32'd0, 32'd33}) begin
      errors++;
      $display("FAIL rearm_impulse: out=%h, required 00000000_00000021", ba.out_data);
    end
  endtask

  task automatic test_gating();
    int v0;
    bit bad = 1'b0;
    int dis_lo [2] = '{6, NT + 1};
    int dis_n  [2] = '{5, 3};
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
    ba.in_valid = 1'b1; ba.in_data = {12'(9), 12'(9)};
    v0 = nvalid;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_600MHz);
      if (ba.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || nvalid != v0) begin
      errors++;
      $display("FAIL unarmed: in_ready seen=%b strobes=%0d, required 0 0", bad, nvalid - v0);
    end
    tick();
    ba.in_valid = 1'b0;
    start_pulse();
    repeat (5) tick();
    @(negedge clk_600MHz);
    checks++;
    if (ba.in_ready !== 1'b1 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_sticky: in_ready=%b busy=%b, required 1 0", ba.in_ready, ba.busy);
    end
    tick();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 1'b1);
    for (int p = 0; p < 2; p++) begin
      bit found = 1'b0;
      ba.in_valid = 1'b1;
      ba.in_data  = {12'(-9 - p), 12'(5 + p)};
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk_600MHz);
        if (ba.in_ready === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL gate_accept pass %0d: in_ready never high, required 1", p);
      end else begin
        model_push(5 + p, -9 - p);
      end
      tick();
      ba.in_valid = 1'b0;
      for (int rel = 1; rel <= NT + 3 + dis_n[p]; rel++) begin
        ba.enable = !(rel >= dis_lo[p] && rel < dis_lo[p] + dis_n[p]);
        @(negedge clk_600MHz);
        checks++;
        if (ba.out_valid !== 1'(rel == NT + 1 + dis_n[p]) ||
            ba.in_ready !== 1'(rel >= NT + 2 + dis_n[p])) begin
          errors++;
          $display("FAIL gate pass %0d t+%0d: out_valid=%b in_ready=%b, required %b %b", p, rel,
                   ba.out_valid, ba.in_ready, rel == NT + 1 + dis_n[p], rel >= NT + 2 + dis_n[p]);
        end
        tick();
      end
      ba.enable = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_impulse();
    test_latency();
    test_sign_ext();
    test_saturation();
    test_coef_protect();
    test_reset_mid_mac();
    test_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
